// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard control unit.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DRAIN  = 2'b01,
    HALTED = 2'b10
  } hazardStateT;

  localparam int DefaultDrainDepth = 3;
  localparam int DefaultCntW       = 16;

  // Load-use hazard: a load in EX writes a register the ID instruction reads.
  function automatic logic loadUseHazard(
    input logic       exMemRead,
    input logic [4:0] exRegRt,
    input logic [4:0] idRs,
    input logic [4:0] idRt,
    input logic       idUsesRt
  );
    return exMemRead && (exRegRt != 5'd0) &&
           ((exRegRt == idRs) || (idUsesRt && (exRegRt == idRt)));
  endfunction

endpackage

// File: rtl/hazard_control_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count
);

  // Clear wins over enable; once all-ones the count is frozen until cleared.
  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (enable && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: load-use stalls, branch flushes, memory freezes
// and an orderly halt that drains EX/MEM/WB before stopping.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int CNT_W       = DefaultCntW,
  parameter int DRAIN_DEPTH = DefaultDrainDepth
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       idRs,
  input  logic [4:0]       idRt,
  input  logic             idUsesRt,
  input  logic             exMemRead,
  input  logic [4:0]       exRegRt,
  input  logic             exBranchTaken,
  input  logic             exJump,
  input  logic             memBusy,
  input  logic             haltReq,
  output logic             pcWrite,
  output logic             ifIdWrite,
  output logic             ifIdFlush,
  output logic             idExBubble,
  output logic             idExHold,
  output logic             pcSrcSel,
  output logic             halted,
  output logic [CNT_W-1:0] stallCount,
  output logic [CNT_W-1:0] flushCount
);

  // Extra headroom bit keeps the width legal even for a zero drain depth.
  localparam int DrainW = $clog2(DRAIN_DEPTH + 2);

  hazardStateT       state, nextState;
  logic [DrainW-1:0] drainCnt, drainNext;
  logic              loadUse;
  logic              stallInc, flushInc;

  // State and drain counter register; reset always returns to RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      drainCnt <= '0;
    end else begin
      state    <= nextState;
      drainCnt <= drainNext;
    end
  end

  // Prioritised control decode plus next-state and counter enables.
  always_comb begin
    pcWrite    = 1'b1;
    ifIdWrite  = 1'b1;
    ifIdFlush  = 1'b0;
    idExBubble = 1'b0;
    idExHold   = 1'b0;
    pcSrcSel   = 1'b0;
    halted     = 1'b0;
    nextState  = state;
    drainNext  = drainCnt;
    stallInc   = 1'b0;
    flushInc   = 1'b0;
    loadUse    = loadUseHazard(exMemRead, exRegRt, idRs, idRt, idUsesRt);

    if (reset) begin
      pcWrite    = 1'b0;
      ifIdWrite  = 1'b0;
      ifIdFlush  = 1'b1;
      idExBubble = 1'b1;
    end else begin
      unique case (state)
        RUN: begin
          if (memBusy) begin
            pcWrite   = 1'b0;
            ifIdWrite = 1'b0;
            idExHold  = 1'b1;
            stallInc  = 1'b1;
          end else if (exBranchTaken || exJump) begin
            pcSrcSel   = 1'b1;
            ifIdFlush  = 1'b1;
            idExBubble = 1'b1;
            flushInc   = 1'b1;
          end else if (loadUse) begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            idExBubble = 1'b1;
            stallInc   = 1'b1;
          end else if (haltReq) begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            idExBubble = 1'b1;
            drainNext  = DrainW'(DRAIN_DEPTH);
            nextState  = DRAIN;
          end
        end
        DRAIN: begin
          pcWrite   = 1'b0;
          ifIdWrite = 1'b0;
          if (memBusy) begin
            idExHold = 1'b1;
          end else begin
            idExBubble = 1'b1;
            if (drainCnt <= DrainW'(1)) begin
              drainNext = '0;
              nextState = HALTED;
            end else begin
              drainNext = drainCnt - DrainW'(1);
            end
          end
        end
        HALTED: begin
          pcWrite    = 1'b0;
          ifIdWrite  = 1'b0;
          idExBubble = 1'b1;
          halted     = 1'b1;
        end
        default: begin
          nextState = RUN;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) stallCounter (
    .clk    (clk),
    .clear  (reset),
    .enable (stallInc),
    .count  (stallCount)
  );

  sat_counter #(.W(CNT_W)) flushCounter (
    .clk    (clk),
    .clear  (reset),
    .enable (flushInc),
    .count  (flushCount)
  );

endmodule
